alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one instance of the 32-bit 3-bit-opcode ALU (module alu) between two requesters.
//  Per-port valid/ready request and response channels; one operation in flight at a time.
//  Round-robin fairness; result is registered and held until the owning requester accepts it.
//  Sits between the pipeline's execute-side clients (e.g. main EX stage, address/aux unit) and the ALU.
// PARAMETERS
//  PRIO_INIT  0   requester given priority first after reset (0 or 1)
//  CNT_W      16  width of the completed-operation counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      asynchronous, active-high reset
//  req_valid    in   2      bit i: requester i presents an operation
//  req_ready    out  2      bit i: arbiter accepts requester i this cycle
//  req_a0/req_b0 in  32     requester 0 operands A/B
//  req_op0      in   3      requester 0 ALUOp (0 add,1 sub,2 and,3 or,4 srl,5 sra,6 ltu-gt,7 signed gt)
//  req_a1/req_b1 in  32     requester 1 operands A/B
//  req_op1      in   3      requester 1 ALUOp
//  resp_valid   out  2      bit i: result for requester i available on resp_c
//  resp_ready   in   2      bit i: requester i takes the result
//  resp_c       out  32     registered ALU result
//  done_cnt     out  CNT_W  number of completed (response-accepted) operations, wraps
// BEHAVIOUR
//  Reset (async): state=IDLE, prio=PRIO_INIT, owner=0, operand/op/result regs=0, done_cnt=0;
//   outputs req_ready=0, resp_valid=0, resp_c=0. In-flight op is dropped, no response issued.
//  FSM states IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: grant g: only one valid -> that one; both valid -> g=prio; none -> no grant.
//   req_ready = onehot(g) when a grant exists, else 0 (combinational from req_valid, state, prio).
//   Never both req_ready bits high. On req_valid[g]&req_ready[g]: latch A,B,op of g, owner=g, -> EXEC.
//  EXEC: ALU driven from latched regs only; C captured into resp_c at end of cycle; -> RESP.
//   req_ready=0. Operands B passed unmodified (shift amount is full B; B>=32 gives 0 / sign fill).
//  RESP: resp_valid[owner]=1, other bit 0; resp_c stable. On resp_ready[owner]: done_cnt+=1,
//   prio=~owner (loser of this round next wins ties), -> IDLE. resp_ready of non-owner ignored.
//  Latency: accept in cycle N -> resp_valid high in cycle N+2; back-to-back issue minimum 3 cycles/op.
//  Requester contract: inputs of the granted port only sampled at the accept edge; may change after.
//  A requester dropping req_valid before accept is legal; grant re-evaluates every IDLE cycle.
//  Non-granted requester's valid is held pending; no starvation: with both continuously valid,
//   grants strictly alternate.
//  done_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//  resp_valid and req_ready are never high in the same cycle.
// TESTING
//  1 After reset, req0: A=3,B=5,op=0 -> req_ready=01 cycle N, resp_valid=01 at N+2, resp_c=8, done_cnt=1.
//  2 Both valid every cycle from reset (PRIO_INIT=0), op0 A=1,B=1 / op1 A=10,B=4 -> grants 0,1,0,1;
//    resp_c sequence 2,6,2,6; never req_ready=11.
//  3 req1 op=5 A=0x80000000 B=4 -> 0xF8000000; op=4 same -> 0x08000000; op=4 B=40 -> 0.
//  4 Compare: op=6 A=0xFFFFFFFF B=1 -> 1; op=7 same operands -> 0; op=1 A=0 B=1 -> 0xFFFFFFFF.
//  5 resp_ready low 3 cycles in RESP (non-owner resp_ready high) -> resp_valid/resp_c held, no new
//    grant, done_cnt unchanged until owner accepts.
//  6 Assert reset during EXEC -> next cycle all outputs 0, state IDLE, no response for dropped op;
//    CNT_W=2 run 5 ops -> done_cnt 1,2,3,0,1.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-requester round-robin front end sharing one 32-bit ALU
// Single operation in flight; result registered and held until the owner accepts it.

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] c
);
    // Shift amount is the full B operand, so any upper bit set means "shifted out".
    logic big_shift;
    assign big_shift = |b[31:5];

    always_comb begin
        c = '0;
        case (op)
            3'd0:    c = a + b;
            3'd1:    c = a - b;
            3'd2:    c = a & b;
            3'd3:    c = a | b;
            3'd4:    c = big_shift ? 32'd0 : (a >> b[4:0]);
            3'd5:    c = big_shift ? {32{a[31]}} : $unsigned($signed(a) >>> b[4:0]);
            3'd6:    c = {31'd0, a > b};
            3'd7:    c = {31'd0, $signed(a) > $signed(b)};
            default: c = '0;
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter logic PRIO_INIT = 1'b0,
    parameter int   CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_b0,
    input  logic [2:0]       req_op0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b1,
    input  logic [2:0]       req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [31:0]      resp_c,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    logic        prio;
    logic        owner;
    logic        grant;
    logic        accept;
    logic        resp_fire;
    logic [31:0] a_q, b_q, alu_c;
    logic [2:0]  op_q;

    alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .c  (alu_c)
    );

    always_comb begin
        state_nxt  = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        grant      = prio;
        accept     = 1'b0;
        resp_fire  = 1'b0;
        case (state)
            IDLE: begin
                // A lone requester wins outright; prio only breaks ties.
                if (req_valid == 2'b01)
                    grant = 1'b0;
                else if (req_valid == 2'b10)
                    grant = 1'b1;
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) begin
                    resp_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= PRIO_INIT;
            owner    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            resp_c   <= '0;
            done_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner <= grant;
                a_q   <= grant ? req_a1  : req_a0;
                b_q   <= grant ? req_b1  : req_b0;
                op_q  <= grant ? req_op1 : req_op0;
            end
            if (state == EXEC)
                resp_c <= alu_c;
            if (resp_fire) begin
                done_cnt <= done_cnt + 1'b1;
                prio     <= ~owner;
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - self-checking bench for alu_rr_arbiter with a transaction-level model

module tb_alu_rr_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [2:0]  req_op0 = '0, req_op1 = '0;
    logic [1:0]  req_ready, resp_valid, req_ready2, resp_valid2;
    logic [31:0] resp_c, resp_c2;
    logic [15:0] done_cnt;
    logic [1:0]  done_cnt2;

    int vectors = 0;
    int miscompares = 0;
    int ops_done = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.PRIO_INIT(1'b0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c), .done_cnt(done_cnt)
    );

    // Narrow-counter copy fed the same traffic, used for the wrap behaviour.
    alu_rr_arbiter #(.PRIO_INIT(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .resp_valid(resp_valid2), .resp_ready(resp_ready), .resp_c(resp_c2), .done_cnt(done_cnt2)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> b;
            3'd5: return $unsigned($signed(a) >>> b);
            3'd6: return (a > b) ? 32'd1 : 32'd0;
            default: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if (req_ready === 2'b11 || resp_valid === 2'b11 || (|req_ready && |resp_valid) ||
                req_ready2 === 2'b11 || (|req_ready2 && |resp_valid2)) begin
                miscompares++;
                $display("FAIL exclusivity: req_ready=%b resp_valid=%b (dut2 %b %b)",
                         req_ready, resp_valid, req_ready2, resp_valid2);
            end
        end
    end

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op);
        if (p == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
        else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
    endtask

    task automatic pulse_reset();
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ops_done = 0;
    endtask

    // Issues one op on port p with the arbiter otherwise idle; returns observations only.
    task automatic send_op(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, output logic [31:0] c, output int lat,
                           output logic [1:0] rr_first);
        int n;
        @(posedge clk); #1;
        set_port(p, a, b, op);
        req_valid[p] = 1'b1;
        @(negedge clk);
        rr_first = req_ready;
        n = 0;
        while (req_ready[p] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        set_port(p, $urandom, $urandom, 3'($urandom_range(0, 7)));
        lat = 0;
        do begin @(negedge clk); lat++; end while (resp_valid[p] !== 1'b1 && lat < 10);
        c = resp_c;
        resp_ready[p] = 1'b1;
        @(posedge clk); #1;
        resp_ready[p] = 1'b0;
        ops_done++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready, resp_valid, resp_c, done_cnt, done_cnt2} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rr=%b rv=%b c=%h cnt=%0d cnt2=%0d, want all 0",
                     req_ready, resp_valid, resp_c, done_cnt, done_cnt2);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle: rr=%b rv=%b, want 00 00", req_ready, resp_valid);
        end
        ops_done = 0;
    endtask

    task automatic test_single();
        logic [31:0] c; int lat; logic [1:0] rr;
        send_op(0, 32'd3, 32'd5, 3'd0, c, lat, rr);
        vectors++;
        if (rr !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b want 01", rr); end
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL single_latency: got %0d want 2", lat); end
        vectors++;
        if (c !== 32'd8) begin miscompares++; $display("FAIL single_result: got %0d want 8", c); end
        @(negedge clk);
        vectors++;
        if (done_cnt !== 16'd1) begin
            miscompares++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_alternation();
        int grants[$];
        logic [31:0] results[$];
        int exp_g[4] = '{0, 1, 0, 1};
        logic [31:0] exp_c[4] = '{32'd2, 32'd6, 32'd2, 32'd6};
        pulse_reset();
        set_port(0, 32'd1, 32'd1, 3'd0);
        set_port(1, 32'd10, 32'd4, 3'd1);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_ready == 2'b01) grants.push_back(0);
            else if (req_ready == 2'b10) grants.push_back(1);
            else if (req_ready != 2'b00) grants.push_back(2);
            if (resp_valid != 2'b00) results.push_back(resp_c);
            @(posedge clk); #1;
        end
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        ops_done   = 4;
        vectors++;
        if (grants.size() != 4 || results.size() != 4) begin
            miscompares++;
            $display("FAIL alt_counts: grants=%0d results=%0d, want 4 4", grants.size(), results.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (grants[i] != exp_g[i] || results[i] !== exp_c[i]) begin
                    miscompares++;
                    $display("FAIL alt_round%0d: grant=%0d c=%0d, want %0d %0d",
                             i, grants[i], results[i], exp_g[i], exp_c[i]);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (done_cnt !== 16'd4) begin miscompares++; $display("FAIL alt_done_cnt: got %0d want 4", done_cnt); end
    endtask

    task automatic test_shifts();
        logic [31:0] c; int lat; logic [1:0] rr;
        logic [31:0] bs[4]  = '{32'd4, 32'd4, 32'd40, 32'd40};
        logic [2:0]  ops[4] = '{3'd5, 3'd4, 3'd4, 3'd5};
        logic [31:0] exp[4] = '{32'hF800_0000, 32'h0800_0000, 32'h0, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            send_op(1, 32'h8000_0000, bs[i], ops[i], c, lat, rr);
            vectors++;
            if (c !== exp[i] || lat !== 2 || rr !== 2'b10) begin
                miscompares++;
                $display("FAIL shift%0d: c=%h lat=%0d rr=%b, want %h 2 10", i, c, lat, rr, exp[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [31:0] c; int lat; logic [1:0] rr;
        logic [31:0] as[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1};
        logic [31:0] bs[4]  = '{32'h1, 32'h1, 32'h1, 32'hFFFF_FFFF};
        logic [2:0]  ops[4] = '{3'd6, 3'd7, 3'd1, 3'd7};
        logic [31:0] exp[4] = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1};
        for (int i = 0; i < 4; i++) begin
            send_op(0, as[i], bs[i], ops[i], c, lat, rr);
            vectors++;
            if (c !== exp[i] || lat !== 2) begin
                miscompares++;
                $display("FAIL compare%0d: c=%h lat=%0d, want %h 2", i, c, lat, exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        int base;
        base = ops_done;
        @(posedge clk); #1;
        set_port(0, 32'd7, 32'd9, 3'd3);
        req_valid = 2'b01;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL hold_grant: got %b want 01", req_ready); end
        @(posedge clk); #1;
        set_port(1, 32'd4, 32'd6, 3'd2);
        req_valid  = 2'b10;
        resp_ready = 2'b10;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            miscompares++; $display("FAIL hold_exec: rr=%b rv=%b want 00 00", req_ready, resp_valid);
        end
        for (int h = 0; h < 4; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            vectors++;
            if (resp_valid !== 2'b01 || resp_c !== 32'd15 || req_ready !== 2'b00 ||
                done_cnt !== 16'(base)) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: rv=%b c=%0d rr=%b cnt=%0d, want 01 15 00 %0d",
                         h, resp_valid, resp_c, req_ready, done_cnt, base);
            end
        end
        resp_ready = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10 || done_cnt !== 16'(base + 1)) begin
            miscompares++;
            $display("FAIL hold_release: rr=%b cnt=%0d, want 10 %0d", req_ready, done_cnt, base + 1);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 2'b10 || resp_c !== 32'd4) begin
            miscompares++; $display("FAIL hold_second: rv=%b c=%0d, want 10 4", resp_valid, resp_c);
        end
        @(posedge clk); #1;
        resp_ready = 2'b00;
        ops_done = base + 2;
    endtask

    task automatic test_reset_exec();
        logic [31:0] c; int lat; logic [1:0] rr;
        @(posedge clk); #1;
        set_port(0, 32'd100, 32'd23, 3'd0);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready, resp_valid, resp_c, done_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_exec_outputs: rr=%b rv=%b c=%h cnt=%0d, want all 0",
                     req_ready, resp_valid, resp_c, done_cnt);
        end
        @(posedge clk); #1 reset = 1'b0;
        ops_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 2'b00 || req_ready !== 2'b00 || done_cnt !== 16'd0) begin
                miscompares++;
                $display("FAIL reset_exec_dropped%0d: rv=%b rr=%b cnt=%0d, want 00 00 0",
                         k, resp_valid, req_ready, done_cnt);
            end
        end
        send_op(1, 32'd2, 32'd3, 3'd3, c, lat, rr);
        vectors++;
        if (rr !== 2'b10 || c !== 32'd3 || lat !== 2) begin
            miscompares++;
            $display("FAIL reset_exec_restart: rr=%b c=%0d lat=%0d, want 10 3 2", rr, c, lat);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] c; int lat; logic [1:0] rr;
        logic [31:0] a, b; logic [2:0] op;
        logic [1:0] exp_w[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom_range(0, 63); op = 3'($urandom_range(0, 7));
            send_op(i % 2, a, b, op, c, lat, rr);
            @(negedge clk);
            vectors++;
            if (done_cnt2 !== exp_w[i] || done_cnt !== 16'(i + 1) || c !== alu_ref(a, b, op)) begin
                miscompares++;
                $display("FAIL wrap%0d: cnt2=%0d cnt=%0d c=%h, want %0d %0d %h",
                         i, done_cnt2, done_cnt, c, exp_w[i], i + 1, alu_ref(a, b, op));
            end
        end
    endtask

    task automatic test_random(input int ncyc);
        logic        busy, prio_m, acc;
        int          owner, resp_at, g;
        logic        pend[2];
        logic [31:0] pa[2], pb[2], exp_c;
        logic [2:0]  pop[2];
        logic [1:0]  exp_rr, rr_tmp;
        pulse_reset();
        busy = 1'b0; prio_m = 1'b0; owner = 0; resp_at = 0; exp_c = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && $urandom_range(0, 9) == 0)
                    pend[i] = 1'b0;
                else if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom_range(0, 255) : $urandom;
                    pb[i]   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    pop[i]  = 3'($urandom_range(0, 7));
                end
                if (pend[i]) set_port(i, pa[i], pb[i], pop[i]);
                else         set_port(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
            end
            req_valid = {pend[1], pend[0]};
            @(negedge clk);
            vectors++;
            if (done_cnt !== 16'(ops_done) || done_cnt2 !== 2'(ops_done)) begin
                miscompares++;
                $display("FAIL rand_cnt cyc%0d: cnt=%0d cnt2=%0d, want %0d", cyc, done_cnt, done_cnt2, ops_done);
            end
            rr_tmp = 2'($urandom);
            if (!busy) begin
                if (pend[0] && pend[1]) g = int'(prio_m);
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
                else                    g = -1;
                exp_rr = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
                vectors++;
                if (req_ready !== exp_rr || resp_valid !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rand_grant cyc%0d: rr=%b rv=%b, want %b 00", cyc, req_ready, resp_valid, exp_rr);
                end
                if (g >= 0) begin
                    busy = 1'b1; owner = g; resp_at = cyc + 2;
                    exp_c = alu_ref(pa[g], pb[g], pop[g]);
                    pend[g] = 1'b0;
                end
            end else if (cyc < resp_at) begin
                vectors++;
                if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rand_exec cyc%0d: rr=%b rv=%b, want 00 00", cyc, req_ready, resp_valid);
                end
            end else begin
                exp_rr = (owner == 0) ? 2'b01 : 2'b10;
                vectors++;
                if (resp_valid !== exp_rr || resp_c !== exp_c || req_ready !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rand_resp cyc%0d: rv=%b c=%h rr=%b, want %b %h 00",
                             cyc, resp_valid, resp_c, req_ready, exp_rr, exp_c);
                end
                acc = ($urandom_range(0, 2) != 0);
                rr_tmp[owner] = acc;
                if (acc) begin
                    ops_done++;
                    prio_m = (owner == 0);
                    busy   = 1'b0;
                end
            end
            resp_ready = rr_tmp;
            @(posedge clk); #1;
        end
        req_valid  = 2'b00;
        resp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternation();
        test_shifts();
        test_compare();
        test_hold();
        test_reset_exec();
        test_wrap();
        test_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
